// File: rtl/mul_seq_pkg.sv
// Shared types for the Booth multiply sequencer: FSM states, Booth pair operations
// and the default operand width.
package mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP,
        BOOTH_ADD_M,
        BOOTH_SUB_M
    } booth_op_e;

    // Radix-2 Booth recoding of the pair {Q[0], Q_1}.
    function automatic booth_op_e booth_op_of(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return BOOTH_ADD_M;
            2'b10:   return BOOTH_SUB_M;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mul_sequencer_booth_decode.sv
// Booth pair decoder: turns {Q[0], Q_1} into the operation plus the external adder's
// B operand and carry-in.
module booth_decode
    import mul_seq_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH + 1
) (
    input  logic         q0,
    input  logic         q_1,
    input  logic [W-1:0] m,
    output booth_op_e    op,
    output logic [W-1:0] add_b,
    output logic         add_cin
);

    always_comb begin
        op      = booth_op_of(q0, q_1);
        add_b   = '0;
        add_cin = 1'b0;
        case (op)
            BOOTH_ADD_M: add_b = m;
            // A - M is formed as A + ~M + 1 so the one external adder serves both cases.
            BOOTH_SUB_M: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_sequencer.sv
// Sequential radix-2 Booth multiplier that borrows an external parallel adder.
// Define MUL_SEQ_SKIP_EN to fold the shift into ADD cycles whose Booth pair needs no add.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH:0]     add_a,
    output logic [WIDTH:0]     add_b,
    output logic               add_cin,
    input  logic [WIDTH:0]     add_sum
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    booth_op_e          booth_op;
    logic [WIDTH:0]     dec_b;
    logic               dec_cin;
    logic               add_active;
    logic               do_shift;
    logic               last_iter;
    logic [WIDTH:0]     sh_a;
    logic [WIDTH-1:0]   sh_q;

    booth_decode #(.W(WIDTH + 1)) u_booth_decode (
        .q0      (q_q[0]),
        .q_1     (q1_q),
        .m       (m_q),
        .op      (booth_op),
        .add_b   (dec_b),
        .add_cin (dec_cin)
    );

    // The adder bus is quiet unless an ADD cycle actually needs an add or subtract.
    always_comb begin
        add_active = (state_q == ST_ADD) && (booth_op != BOOTH_NOP);
        add_a      = add_active ? a_q   : '0;
        add_b      = add_active ? dec_b : '0;
        add_cin    = add_active & dec_cin;
    end

    always_comb begin
`ifdef MUL_SEQ_SKIP_EN
        do_shift  = (state_q == ST_SHIFT) ||
                    ((state_q == ST_ADD) && (booth_op == BOOTH_NOP));
`else
        do_shift  = (state_q == ST_SHIFT);
`endif
        sh_a      = {a_q[WIDTH], a_q[WIDTH:1]};
        sh_q      = {a_q[0], q_q[WIDTH-1:1]};
        last_iter = (count_q == CW'(WIDTH - 1));
    end

    always_comb begin
        // NOTE: every _d starts from its _q (done from 0) so no path leaves a variable unassigned and infers a latch.
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    m_d     = {op_a[WIDTH-1], op_a};
                    q_d     = op_b;
                    q1_d    = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (booth_op != BOOTH_NOP) begin
                    a_d = add_sum;
                end
                state_d = ST_SHIFT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        // Arithmetic right shift of {A,Q,Q_1}; in skip mode this also overrides a NOP ADD.
        if (do_shift) begin
            a_d     = sh_a;
            q_d     = sh_q;
            q1_d    = q_q[0];
            count_d = count_q + CW'(1);
            if (last_iter) begin
                state_d   = ST_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                product_d = {sh_a[WIDTH-1:0], sh_q};
            end else begin
                state_d = ST_ADD;
            end
        end
    end

    // NOTE: flops use <= so each one samples pre-edge values no matter the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a behavioural adder and product/latency model.
module tb_mul_sequencer;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;
    logic [W:0]       add_a;
    logic [W:0]       add_b;
    logic             add_cin;
    logic [W:0]       add_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External parallel adder.
    assign add_sum = add_a + add_b + {{W{1'b0}}, add_cin};

    mul_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_sum (add_sum)
    );

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, p;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        p  = sa * sb;
        return p;
    endfunction

    // Cycles from accept edge to done edge.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_SEQ_SKIP_EN
        int   n;
        logic prev;
        n    = W;
        prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (b[i] != prev) n++;
            prev = b[i];
        end
        return n;
`else
        return 2 * W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a multiply, optionally pulses start again at cycle inj_cycle, and waits for done.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_cycle, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output logic [2*W-1:0] prod,
                          output bit busy_ok, output logic [2*W-1:0] prod_at_accept);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        tick();
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        prod_at_accept = product;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        lat  = -1;
        prod = 'x;
        for (int k = 1; k <= 4 * W; k++) begin
            if (k == inj_cycle) begin
                start = 1'b1;
                op_a  = ia;
                op_b  = ib;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                lat  = k;
                prod = product;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags busy/done got %b want 00", {busy, done});
        end
        checks++;
        if (product !== '0) begin
            errors++;
            $display("FAIL reset_product got %h want 0000", product);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL reset_adder_bus got %h/%h/%b want 0", add_a, add_b, add_cin);
        end
        // Reset wins over start on the same edge.
        start = 1'b1;
        op_a  = 8'd3;
        op_b  = 8'd3;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit ok;
        logic [2*W-1:0] p, pa;
        do_mul(8'd7, 8'd3, -1, '0, '0, lat, p, ok, pa);
        checks++;
        if (p !== 16'h0015) begin
            errors++;
            $display("FAIL basic_product got %h want 0015", p);
        end
        checks++;
        if (lat !== exp_lat(8'd3)) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", lat, exp_lat(8'd3));
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_busy got irregular want high until done");
        end
        tick();
        checks++;
        if ({busy, done, product} !== {2'b00, 16'h0015}) begin
            errors++;
            $display("FAIL basic_after got busy=%b done=%b prod=%h want 0 0 0015", busy, done, product);
        end
    endtask

    task automatic test_adder_bus();
        int viol;
        int lat;
        bit ok;
        logic [2*W-1:0] p, pa;
        // op_b=1: the first Booth pair is 10, so the first ADD cycle subtracts M.
        start = 1'b1;
        op_a  = 8'h23;
        op_b  = 8'h01;
        tick();
        start = 1'b0;
        checks++;
        if ({add_a, add_b, add_cin} !== {9'd0, ~9'h023, 1'b1}) begin
            errors++;
            $display("FAIL adder_sub got %h/%h/%b want 000/%h/1", add_a, add_b, add_cin, ~9'h023);
        end
        viol = 0;
        for (int k = 0; k < 4 * W && done !== 1'b1; k++) tick();
        checks++;
        if (product !== ref_product(8'h23, 8'h01)) begin
            errors++;
            $display("FAIL adder_sub_product got %h want %h", product, ref_product(8'h23, 8'h01));
        end
        tick();
        // op_b=0: every pair is 00, so the adder bus must stay at zero throughout.
        start = 1'b1;
        op_a  = 8'h5A;
        op_b  = 8'h00;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4 * W && done !== 1'b1; k++) begin
            if ({add_a, add_b, add_cin} !== '0) viol++;
            tick();
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL adder_idle_bus got %0d nonzero cycles want 0", viol);
        end
        tick();
        do_mul(8'h01, 8'h01, -1, '0, '0, lat, p, ok, pa);
        tick();
    endtask

    task automatic test_corners();
        logic [W-1:0]   ca [6] = '{8'h80, 8'hFB, 8'h05, 8'h05, 8'h7F, 8'hFF};
        logic [W-1:0]   cb [6] = '{8'h80, 8'h04, 8'h00, 8'h55, 8'h80, 8'hFF};
        logic [2*W-1:0] cp [6] = '{16'h4000, 16'hFFEC, 16'h0000, 16'h01A9, 16'hC080, 16'h0001};
        int lat;
        bit ok;
        logic [2*W-1:0] p, pa;
        for (int i = 0; i < 6; i++) begin
            do_mul(ca[i], cb[i], -1, '0, '0, lat, p, ok, pa);
            checks++;
            if (p !== cp[i]) begin
                errors++;
                $display("FAIL corner%0d_product %h*%h got %h want %h", i, ca[i], cb[i], p, cp[i]);
            end
            checks++;
            if (lat !== exp_lat(cb[i])) begin
                errors++;
                $display("FAIL corner%0d_latency got %0d want %0d", i, lat, exp_lat(cb[i]));
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit ok;
        logic [2*W-1:0] p, pa;
        do_mul(8'd6, 8'd7, 4, 8'd2, 8'd2, lat, p, ok, pa);
        checks++;
        if (p !== 16'h002A || lat !== exp_lat(8'd7)) begin
            errors++;
            $display("FAIL ignore_start got prod=%h lat=%0d want 002A lat=%0d", p, lat, exp_lat(8'd7));
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_queue busy got %b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int spurious;
        bit ok;
        logic [2*W-1:0] p, pa;
        start = 1'b1;
        op_a  = 8'd9;
        op_b  = 8'd9;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, product} !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b done=%b prod=%h want 0 0 0000", busy, done, product);
        end
        spurious = 0;
        for (int k = 0; k < 3 * W; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL mid_reset_idle got %0d active cycles want 0", spurious);
        end
        do_mul(8'd2, 8'd2, -1, '0, '0, lat, p, ok, pa);
        checks++;
        if (p !== 16'h0004 || lat !== exp_lat(8'd2)) begin
            errors++;
            $display("FAIL mid_reset_recover got prod=%h lat=%0d want 0004 lat=%0d", p, lat, exp_lat(8'd2));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        logic [2*W-1:0] p, pa;
        do_mul(8'd11, 8'hFD, -1, '0, '0, lat, p, ok, pa);
        checks++;
        if (p !== ref_product(8'd11, 8'hFD)) begin
            errors++;
            $display("FAIL b2b_first got %h want %h", p, ref_product(8'd11, 8'hFD));
        end
        tick();
        do_mul(8'd100, 8'd2, -1, '0, '0, lat, p, ok, pa);
        checks++;
        if (pa !== ref_product(8'd11, 8'hFD)) begin
            errors++;
            $display("FAIL b2b_hold got %h want %h", pa, ref_product(8'd11, 8'hFD));
        end
        checks++;
        if (!ok || lat !== exp_lat(8'd2)) begin
            errors++;
            $display("FAIL b2b_accept got busy_ok=%0d lat=%0d want 1 lat=%0d", ok, lat, exp_lat(8'd2));
        end
        checks++;
        if (p !== 16'h00C8) begin
            errors++;
            $display("FAIL b2b_second got %h want 00C8", p);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        bit ok;
        logic [2*W-1:0] p, pa;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            do_mul(a, b, -1, '0, '0, lat, p, ok, pa);
            checks++;
            if (p !== ref_product(a, b) || lat !== exp_lat(b) || !ok) begin
                errors++;
                $display("FAIL random%0d %h*%h got prod=%h lat=%0d busy_ok=%0d want %h lat=%0d",
                         i, a, b, p, lat, ok, ref_product(a, b), exp_lat(b));
            end
            repeat (1 + $urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_adder_bus();
        test_corners();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand width. The shared adder width is WIDTH+1.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  signed multiplicand M; captured on accept.
REQ-006 op_b  input  WIDTH  signed multiplier Q; captured on accept.
REQ-007 busy  output  1  high while a multiply is in progress.
REQ-008 done  output  1  one-cycle pulse when product is valid.
REQ-009 product  output  2*WIDTH  signed product; held until the next accept.
REQ-010 add_a  output  WIDTH+1  operand A to the external parallel_adder.
REQ-011 add_b  output  WIDTH+1  operand B to the external parallel_adder.
REQ-012 add_cin  output  1  carry-in to the external parallel_adder.
REQ-013 add_sum  input  WIDTH+1  sum returned from the external parallel_adder.

Function
REQ-014 The block SHALL implement radix-2 Booth multiplication with these registers:
- accumulator A, WIDTH+1 bits
- M, sign-extended to WIDTH+1 bits
- Q, WIDTH bits
- Q_1, 1 bit
- iteration counter, clog2(WIDTH)+1 bits
REQ-015 The FSM SHALL have states IDLE, ADD, SHIFT and DONE.
REQ-016 In IDLE with start=1, at that edge: load A=0, M=sext(op_a), Q=op_b, Q_1=0, count=0; go to ADD.
REQ-017 ADD SHALL act on {Q[0],Q_1}:
- 01: A<=add_sum with add_a=A, add_b=M, add_cin=0.
- 10: A<=add_sum with add_a=A, add_b=~M, add_cin=1.
- 00 or 11: A unchanged.
- Next state: SHIFT.
REQ-018 SHIFT SHALL arithmetic-shift {A,Q,Q_1} right by one (A[WIDTH] replicated) and increment count; next state is DONE when count reaches WIDTH-1 before the increment, otherwise ADD.
REQ-019 DONE SHALL hold for one cycle with done=1 and product={A[WIDTH-1:0],Q}, then go to IDLE.
REQ-020 Latency without the macro SHALL be fixed: with start accepted at edge E0, busy=1 from E0 to E2*WIDTH and done=1 from E2*WIDTH to E2*WIDTH+1 (edges 16/17 for WIDTH=8).
REQ-021 Outside an ADD state performing 01/10, add_a, add_b and add_cin SHALL be driven to 0.
REQ-022 start SHALL be ignored in ADD, SHIFT and DONE; operands are not re-sampled; no queueing.
REQ-023 Back-to-back: start accepted in the IDLE cycle immediately after DONE SHALL begin a new multiply with no extra idle cycle.
REQ-024 The most-negative case (-2^(WIDTH-1))^2 SHALL produce the correct positive product with no overflow.

Reset
REQ-025 rst=1 at any edge, including mid-operation, SHALL force IDLE with A, M, Q, Q_1, count, product=0 and busy=0, done=0.
REQ-026 rst has priority over start at the same edge.

Configuration
REQ-027 Macro MUL_SEQ_SKIP_EN, when defined: in ADD with {Q[0],Q_1} = 00 or 11, the block SHALL perform the SHIFT action in that cycle and go directly to the next ADD or DONE.
- Latency becomes WIDTH + (number of 01/10 iterations).
- All other rules are unchanged.
REQ-028 Without MUL_SEQ_SKIP_EN, latency SHALL be exactly 2*WIDTH cycles per REQ-020.

Structure
REQ-029 Package mul_seq_pkg SHALL hold:
- the state enum (IDLE, ADD, SHIFT, DONE)
- default WIDTH=8
- Booth pair encodings (NOP, ADD_M, SUB_M)
REQ-030 parallel_adder SHALL stay external, connected at the parent through add_a/add_b/add_cin/add_sum; the block SHALL contain no adder.
REQ-031 One optional sub-module, booth_decode, SHALL be the only sub-module: it maps {Q[0],Q_1} to add_b/add_cin selection.

Verification
REQ-032 op_a=7, op_b=3, start pulse -> done at edge 16 after accept, product=0x0015, busy low after.
REQ-033 op_a=-128, op_b=-128 -> product=0x4000; op_a=-5, op_b=4 -> product=0xFFEC.
REQ-034 Accept 6x7, re-assert start with 2x2 at cycle 4 -> ignored; product=0x002A.
REQ-035 Accept 9x9, rst at cycle 5 -> busy=0, done=0, product=0 next cycle; then 2x2 -> product=0x0004.
REQ-036 With MUL_SEQ_SKIP_EN, op_a=5, op_b=0 -> done 8 cycles after accept, product=0; op_b=0x55 -> 16 cycles, product=0x01A9.
REQ-037 done asserted in cycle N and start in cycle N+1 -> second multiply accepted; product holds its old value until the second done.
